comparator_1bit_bist: RTL and testbench

- Self-test driver and checker for the 1-bit magnitude comparator. It is the driving/checking end of that comparator's a/b -> y interface.
- It sweeps a,b through all four input combinations and samples the comparator's y[2:0] for each one.
- Each sample is checked against the expected code. The block reports pass/fail, an error count and the first failing vector.
- It sits beside the comparator instance in the behavioral project so the comparator can be checked in hardware without a bench.

---
 rtl/comparator_1bit_bist.sv | 142 ++++++++++++++
 tb/tb_comparator_1bit_bist.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/comparator_1bit_bist.sv
// Self-test driver/checker for the 1-bit magnitude comparator: sweeps {a,b}, checks y, reports pass/errors.
// Optional COMP_BIST_STOP_ON_FAIL_EN: the first mismatch ends the run early.
module comparator_1bit_bist #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [2:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ERR_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               first_fail, first_fail_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic [1:0]         fail_vec_nxt;
  logic               pass_nxt;
  logic               a_nxt, b_nxt, busy_nxt, done_nxt;
  logic [2:0]         expected_c;
  logic               sample_c, mismatch_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Expected code for the vector being driven and the sample strobe
  always_comb begin
    expected_c = 3'b010;
    case (idx)
      2'd0:    expected_c = 3'b010;
      2'd1:    expected_c = 3'b001;
      2'd2:    expected_c = 3'b100;
      default: expected_c = 3'b010;
    endcase
    sample_c   = (state == RUN) && (cnt == CNT_W'(HOLD_CYCLES - 1));
    mismatch_c = sample_c && (y != expected_c);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (sample_c) begin
`ifdef COMP_BIST_STOP_ON_FAIL_EN
          if (mismatch_c || (idx == IDX_W'(3))) state_nxt = REPORT;
`else
          if (idx == IDX_W'(3)) state_nxt = REPORT;
`endif
        end
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered from the next state
  always_comb begin
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    err_nxt        = err_count;
    fail_vec_nxt   = fail_vec;
    first_fail_nxt = first_fail;
    pass_nxt       = pass;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt        = '0;
          cnt_nxt        = '0;
          err_nxt        = '0;
          fail_vec_nxt   = 2'b00;
          first_fail_nxt = 1'b0;
          pass_nxt       = 1'b0;
        end
      end
      RUN: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (sample_c) begin
          cnt_nxt = '0;
          if (idx != IDX_W'(3)) idx_nxt = idx + IDX_W'(1);
          if (mismatch_c) begin
            err_nxt = err_count + ERR_W'(1);
            if (!first_fail) begin
              fail_vec_nxt   = {a, b};
              first_fail_nxt = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if ((state_nxt == REPORT) && (state != REPORT)) pass_nxt = (err_nxt == '0);
    busy_nxt         = (state_nxt == RUN);
    done_nxt         = (state_nxt == REPORT);
    {a_nxt, b_nxt}   = busy_nxt ? idx_nxt : 2'b00;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      first_fail <= 1'b0;
      err_count  <= '0;
      fail_vec   <= 2'b00;
      pass       <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      first_fail <= first_fail_nxt;
      err_count  <= err_nxt;
      fail_vec   <= fail_vec_nxt;
      pass       <= pass_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_comparator_1bit_bist.sv
// Scoreboard bench for comparator_1bit_bist: a behavioral comparator with selectable faults feeds y.
module tb_comparator_1bit_bist;

  localparam int unsigned H = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a, b;
  logic [2:0] y;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;

  int mode = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int exp_done = 0;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [1:0] fv;
    int         lat;
    int         bcnt;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];

  comparator_1bit_bist #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Comparator model: 0 correct, 1 stuck at 010, 2 gt/lt swapped, 3 illegal 111 on vector 11
  always_comb begin
    y = 3'b010;
    case (mode)
      1: y = 3'b010;
      2: y = (a > b) ? 3'b001 : (a == b) ? 3'b010 : 3'b100;
      3: y = (a & b) ? 3'b111 : (a == b) ? 3'b010 : 3'b001;
      default: y = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
    endcase
    if (mode == 3 && a && !b) y = 3'b100;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic p, input int e, input int fv, input int lat,
                              input int bcnt, input logic [3:0] mask);
    exp_t r;
    r.pass = p; r.err = 3'(e); r.fv = 2'(fv); r.lat = lat; r.bcnt = bcnt; r.mask = mask;
    return r;
  endfunction

  // Monitor: tracks each run from busy rising and checks the report when done pulses
  initial begin
    int acc = 0;
    int bcnt = 0;
    logic prev_busy = 1'b0;
    logic [3:0] mask = 4'h0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        acc = cyc; bcnt = 0; mask = 4'h0;
      end
      if (busy) begin
        bcnt++;
        mask[{a, b}] = 1'b1;
      end
      prev_busy = busy;
      if (done) begin
        n_done++;
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("pass", int'(pass), int'(e.pass));
          check("err_count", int'(err_count), int'(e.err));
          check("fail_vec", int'(fail_vec), int'(e.fv));
          check("done_latency", cyc - acc, e.lat);
          check("busy_cycles", bcnt, e.bcnt);
          check("vectors_driven", int'(mask), int'(e.mask));
          check("busy_in_report", int'(busy), 0);
        end
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    while (n_done < exp_done && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("done_timeout", n_done, exp_done);
  endtask

  task automatic run(input int m, input exp_t e);
    mode = m;
    sb.push_back(e);
    exp_done++;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
  endtask

  exp_t e_good, e_stuck, e_swap, e_ill;

  initial begin
    int t;
    e_good = mk(1'b1, 0, 0, 4*H, 4*H, 4'hF);
`ifdef COMP_BIST_STOP_ON_FAIL_EN
    e_stuck = mk(1'b0, 1, 1, 2*H, 2*H, 4'h3);
    e_swap  = mk(1'b0, 1, 1, 2*H, 2*H, 4'h3);
`else
    e_stuck = mk(1'b0, 2, 1, 4*H, 4*H, 4'hF);
    e_swap  = mk(1'b0, 2, 1, 4*H, 4*H, 4'hF);
`endif
    e_ill = mk(1'b0, 1, 3, 4*H, 4*H, 4'hF);

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_fail_vec", int'(fail_vec), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, e_good);
    run(1, e_stuck);
    run(2, e_swap);
    run(3, e_ill);

    // Mid-run pulse is ignored; held start re-runs after REPORT plus one IDLE cycle
    mode = 1;
    sb.push_back(e_stuck);
    sb.push_back(e_stuck);
    exp_done += 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("held_first_done_seen", int'(done), 1);
    @(negedge clk);
    check("held_idle_busy", int'(busy), 0);
    check("held_idle_done", int'(done), 0);
    @(negedge clk);
    check("held_restart_busy", int'(busy), 1);
    check("held_restart_err_cleared", int'(err_count), 0);
    check("held_restart_pass_cleared", int'(pass), 0);
    start = 1'b0;
    wait_done();

    // Asynchronous reset while vector 10 is applied
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while (!(a && !b) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reached_vec_10", int'({a, b}), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", int'(a), 0);
    check("async_rst_b", int'(b), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_pass", int'(pass), 0);
    check("async_rst_err_count", int'(err_count), 0);
    check("async_rst_fail_vec", int'(fail_vec), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run(0, e_good);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", n_done, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
